// File: rtl/ll3_h_burst_arbiter.sv
// Round-robin burst arbiter: two Xronos token streams share one output port, whole bursts per grant.
// Optional starvation abort enabled by defining LL3_H_ARB_TIMEOUT_EN.
module ll3_h_burst_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic              In1_SEND,
  input  logic [15:0]       In1_COUNT,
  output logic              In1_ACK,
  input  logic [DATA_W-1:0] In2_DATA,
  input  logic              In2_SEND,
  input  logic [15:0]       In2_COUNT,
  output logic              In2_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic              Out1_SEND,
  output logic [15:0]       Out1_COUNT,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK,
  output logic              Grant_ID,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [15:0] LAST = 16'(BURST_LEN - 1);

  state_t      state, state_nxt;
  logic        prio, prio_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        in_grant, is_b, g_send, o_send, fire, burst_end, abort;

  logic unused_inputs;
  assign unused_inputs = ^{In1_COUNT, In2_COUNT, Out1_ACK};

  assign in_grant  = (state != IDLE);
  assign is_b      = (state == GRANT_B);
  assign g_send    = in_grant & (is_b ? In2_SEND : In1_SEND);
  assign o_send    = is_b ? In1_SEND : In2_SEND;
  assign fire      = g_send & Out1_RDY & ~RESET;
  assign burst_end = fire & (cnt == LAST);

`ifdef LL3_H_ARB_TIMEOUT_EN
  localparam logic [15:0] STARVE_LAST = 16'(TIMEOUT - 1);
  logic [15:0] starve;
  logic        starve_inc;

  assign starve_inc = in_grant & ~g_send & Out1_RDY;
  assign abort      = starve_inc & (starve == STARVE_LAST) & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET || fire || abort || (state_nxt != state))
      starve <= '0;
    else if (starve_inc)
      starve <= starve + 16'd1;
  end
`else
  localparam logic [15:0] UNUSED_TIMEOUT = 16'(TIMEOUT);
  logic [15:0] unused_timeout;
  assign unused_timeout = UNUSED_TIMEOUT;
  assign abort = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      if (In1_SEND && (!In2_SEND || !prio)) begin
        state_nxt = GRANT_A;
        cnt_nxt   = '0;
      end else if (In2_SEND) begin
        state_nxt = GRANT_B;
        cnt_nxt   = '0;
      end
    end else if (burst_end || abort) begin
      // Handover prefers the other port; an abort has g_send low so it never re-grants the same port.
      prio_nxt = ~is_b;
      cnt_nxt  = '0;
      if (o_send)
        state_nxt = is_b ? GRANT_A : GRANT_B;
      else if (g_send)
        state_nxt = state;
      else
        state_nxt = IDLE;
    end else if (fire) begin
      cnt_nxt = cnt + 16'd1;
    end
  end

  always_comb begin
    In1_ACK    = fire & ~is_b;
    In2_ACK    = fire & is_b;
    Out1_SEND  = fire;
    Out1_COUNT = 16'h1;
    Busy       = in_grant & ~RESET;
    Grant_ID   = is_b & ~RESET;
    Out1_DATA  = '0;
    if (!RESET && in_grant)
      Out1_DATA = is_b ? In2_DATA : In1_DATA;
  end

endmodule
